// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to imem and
// buffers in-order responses as {PC, IR} for the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        CLR,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        EN,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        Out,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic        bb
);

  localparam int unsigned AW = $clog2(FB_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] DEPTH = (CW+2)'(FB_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pcq_mem [FB_DEPTH];
  logic [AW-1:0] pcq_rd, pcq_wr;
  logic [CW-1:0] pcq_cnt;
  logic [31:0]   ib_pc [FB_DEPTH];
  logic [31:0]   ib_ir [FB_DEPTH];
  logic [AW-1:0] ib_rd, ib_wr;
  logic [CW-1:0] ib_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_redir;
  logic [CW+1:0] used;
  logic          grant, accept, drop_rsp, pop, out_v;

  always_comb begin
    used     = (CW+2)'(pcq_cnt) + (CW+2)'(drop_cnt) + (CW+2)'(ib_cnt);
    imem_req = !CLR && !redirect && (used < DEPTH);
    grant    = imem_req && imem_gnt;
    drop_rsp = imem_rvalid && (drop_cnt != '0);
    accept   = imem_rvalid && (drop_cnt == '0) && (pcq_cnt != '0) && !redirect;
    out_v    = (ib_cnt != '0) && !redirect;
    pop      = EN && out_v;
    // Every outstanding request becomes a drop; a response landing in the
    // redirect cycle retires one of them (guarded against a stray response).
    drop_redir = drop_cnt + pcq_cnt;
    if (imem_rvalid && (drop_redir != '0))
      drop_redir = drop_redir - CW'(1);
  end

  assign imem_addr = fetch_pc;
  assign Out       = out_v;
  assign IR        = out_v ? ib_ir[ib_rd] : '0;
  assign PC        = out_v ? ib_pc[ib_rd] : '0;
  assign bb        = !out_v;

  // Storage arrays need no reset: validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (grant)
      pcq_mem[pcq_wr] <= fetch_pc;
    if (accept) begin
      ib_pc[ib_wr] <= pcq_mem[pcq_rd];
      ib_ir[ib_wr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      pcq_rd   <= '0;
      pcq_wr   <= '0;
      pcq_cnt  <= '0;
      ib_rd    <= '0;
      ib_wr    <= '0;
      ib_cnt   <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      pcq_rd   <= '0;
      pcq_wr   <= '0;
      pcq_cnt  <= '0;
      ib_rd    <= '0;
      ib_wr    <= '0;
      ib_cnt   <= '0;
      drop_cnt <= drop_redir;
    end else begin
      if (grant) begin
        pcq_wr   <= pcq_wr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (accept) begin
        pcq_rd <= pcq_rd + AW'(1);
        ib_wr  <= ib_wr + AW'(1);
      end
      if (pop)
        ib_rd <= ib_rd + AW'(1);
      pcq_cnt <= pcq_cnt + CW'(grant) - CW'(accept);
      ib_cnt  <= ib_cnt + CW'(accept) - CW'(pop);
      if (drop_rsp)
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

endmodule
